// File: rtl/memwb_multi_pipe_if.sv
// memwb_multi_pipe_if
//   Per-channel MEM->WB bus for memwb_multi_pipe.
//   in_*  : instruction fields arriving from EX/MEM (driven by master).
//   out_* : registered write-back fields toward the register file (driven by slave).
//   Channel i occupies bit i of valid/we, [i*REG_AW +: REG_AW] of rdest
//   and [i*XLEN +: XLEN] of res.
interface memwb_multi_pipe_if #(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 2,
    parameter int REG_AW = 5
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_we;
    logic [NUM_CH*REG_AW-1:0] in_rdest;
    logic [NUM_CH*XLEN-1:0]   in_res;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_we;
    logic [NUM_CH*REG_AW-1:0] out_rdest;
    logic [NUM_CH*XLEN-1:0]   out_res;

    modport master (
        output in_valid, in_we, in_rdest, in_res,
        input  out_valid, out_we, out_rdest, out_res
    );

    modport slave (
        input  in_valid, in_we, in_rdest, in_res,
        output out_valid, out_we, out_rdest, out_res
    );
endinterface

// File: rtl/memwb_multi_pipe.sv
// memwb_multi_pipe
//   MEM->WB pipeline register for a NUM_CH-wide issue core.
//   Captures valid / qualified write enable / dest reg / result per channel,
//   supports stall-hold, bubble insertion and flush, suppresses x0 writes,
//   lets the youngest channel win same-register conflicts, and counts
//   retired instructions.
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-low
//   stall    global stall bus; this stage is bit STAGE
//   flush    discard stage contents
//   bus      slave side of memwb_multi_pipe_if (in_* captured, out_* registered)
//   instret  retired-instruction counter (wraps)
module memwb_multi_pipe #(
    parameter int XLEN    = 32,
    parameter int NUM_CH  = 2,
    parameter int REG_AW  = 5,
    parameter int STALL_W = 6,
    parameter int STAGE   = 4,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    memwb_multi_pipe_if.slave  bus,
    output logic [CNT_W-1:0]   instret
);
    logic              next_stall;
    logic [NUM_CH-1:0] we_q;
    logic [NUM_CH-1:0] we_fin;
    logic [CNT_W-1:0]  n_valid;

    // The last stage in the bus has no downstream stall to look at.
    generate
        if (STAGE < STALL_W - 1) begin : g_next
            assign next_stall = stall[STAGE+1];
        end else begin : g_last
            assign next_stall = 1'b0;
        end
    endgenerate

    always_comb begin
        we_q    = '0;
        we_fin  = '0;
        n_valid = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            we_q[i] = bus.in_valid[i] && bus.in_we[i]
                      && (bus.in_rdest[i*REG_AW +: REG_AW] != '0);
            n_valid = n_valid + CNT_W'(bus.in_valid[i]);
        end
        // An older channel loses its write if any younger channel writes the same register.
        we_fin = we_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            for (int unsigned j = i + 1; j < NUM_CH; j++) begin
                if (we_q[i] && we_q[j]
                    && (bus.in_rdest[i*REG_AW +: REG_AW] == bus.in_rdest[j*REG_AW +: REG_AW]))
                    we_fin[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.out_valid <= '0;
            bus.out_we    <= '0;
            bus.out_rdest <= '0;
            bus.out_res   <= '0;
            instret       <= '0;
        end else if (flush || (stall[STAGE] && !next_stall)) begin
            bus.out_valid <= '0;
            bus.out_we    <= '0;
            bus.out_rdest <= '0;
            bus.out_res   <= '0;
        end else if (!stall[STAGE]) begin
            bus.out_valid <= bus.in_valid;
            bus.out_we    <= we_fin;
            bus.out_rdest <= bus.in_rdest;
            bus.out_res   <= bus.in_res;
            instret       <= instret + n_valid;
        end
    end
endmodule

// File: tb/tb_memwb_multi_pipe.sv
// tb_memwb_multi_pipe
//   Directed bench for memwb_multi_pipe: a default instance (CNT_W=64) and a
//   CNT_W=8 instance share the same stimulus so counter wrap can be reached.
module tb_memwb_multi_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall;
    logic       flush;
    logic [63:0] instret;
    logic [7:0]  instret8;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memwb_multi_pipe_if #(.XLEN(32), .NUM_CH(2), .REG_AW(5)) bus  ();
    memwb_multi_pipe_if #(.XLEN(32), .NUM_CH(2), .REG_AW(5)) bus8 ();

    memwb_multi_pipe #(.XLEN(32), .NUM_CH(2), .REG_AW(5), .STALL_W(6), .STAGE(4), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus.slave), .instret(instret)
    );
    memwb_multi_pipe #(.XLEN(32), .NUM_CH(2), .REG_AW(5), .STALL_W(6), .STAGE(4), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus8.slave), .instret(instret8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [4:0] rd0, input logic [4:0] rd1,
                         input logic [31:0] r0, input logic [31:0] r1);
        bus.in_valid  = v;        bus8.in_valid = v;
        bus.in_we     = we;       bus8.in_we    = we;
        bus.in_rdest  = {rd1, rd0}; bus8.in_rdest = {rd1, rd0};
        bus.in_res    = {r1, r0};   bus8.in_res   = {r1, r0};
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [1:0] v, input logic [1:0] we,
                              input logic [9:0] rd, input logic [63:0] res);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
        check({tag, ".we"},    64'(bus.out_we),    64'(we));
        check({tag, ".rdest"}, 64'(bus.out_rdest), 64'(rd));
        check({tag, ".res"},   bus.out_res,        res);
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0;
        drive('0, '0, '0, '0, '0, '0);
        @(negedge clk);

        // 1: reset with random inputs, then first load
        for (int k = 0; k < 2; k++) begin
            drive(2'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom);
            stall = 6'($urandom);
            flush = 1'($urandom);
            step();
        end
        check_outs("rst", 2'b00, 2'b00, 10'h0, 64'h0);
        check("rst.instret", instret, 64'd0);
        check("rst.instret8", 64'(instret8), 64'd0);
        rst = 1'b1; stall = '0; flush = 1'b0;
        drive(2'b11, 2'b11, 5'd1, 5'd2, 32'hA, 32'hB);
        step();
        check_outs("load1", 2'b11, 2'b11, {5'd2, 5'd1}, {32'hB, 32'hA});
        check("load1.instret", instret, 64'd2);

        // 2: x0 write suppressed on ch1
        drive(2'b11, 2'b11, 5'd3, 5'd0, 32'hDEAD, 32'h5);
        step();
        check_outs("x0", 2'b11, 2'b01, {5'd0, 5'd3}, {32'h5, 32'hDEAD});
        check("x0.instret", instret, 64'd4);

        // 3: same-rd conflict, youngest wins
        drive(2'b11, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22);
        step();
        check_outs("conf", 2'b11, 2'b10, {5'd7, 5'd7}, {32'h22, 32'h11});
        check("conf.instret", instret, 64'd6);

        // 4: hold for 3 cycles with changing inputs, then bubble
        stall = 6'b110000;
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 2'b11, 5'(k + 9), 5'(k + 12), 32'(k), 32'(k + 100));
            step();
            check_outs("hold", 2'b11, 2'b10, {5'd7, 5'd7}, {32'h22, 32'h11});
            check("hold.instret", instret, 64'd6);
        end
        stall = 6'b010000;
        step();
        check_outs("bubble", 2'b00, 2'b00, 10'h0, 64'h0);
        check("bubble.instret", instret, 64'd6);

        // single valid channel, invalid channel's write is dropped
        stall = '0;
        drive(2'b01, 2'b11, 5'd4, 5'd6, 32'h44, 32'h66);
        step();
        check_outs("one", 2'b01, 2'b01, {5'd6, 5'd4}, {32'h66, 32'h44});
        check("one.instret", instret, 64'd7);

        // 5: flush beats a hold-stall
        stall = 6'b110000; flush = 1'b1;
        drive(2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2);
        step();
        check_outs("flush", 2'b00, 2'b00, 10'h0, 64'h0);
        check("flush.instret", instret, 64'd7);
        flush = 1'b0;

        // reset while holding clears the stage
        stall = '0;
        step();
        stall = 6'b110000; rst = 1'b0;
        step();
        check_outs("rsthold", 2'b00, 2'b00, 10'h0, 64'h0);
        check("rsthold.instret", instret, 64'd0);
        rst = 1'b1; stall = '0;

        // 6: bring the 8-bit counter to 255, then wrap
        drive(2'b11, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        for (int k = 0; k < 127; k++) step();
        drive(2'b01, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        check("pre.instret8", 64'(instret8), 64'd255);
        check("pre.instret", instret, 64'd255);
        drive(2'b11, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        check("wrap.instret8", 64'(instret8), 64'd1);
        check("wrap.instret", instret, 64'd257);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
